load_store_unit: RTL and testbench

Core-side initiator for the word-wide memory interface served by `memory_controller`. Accepts RISC-V load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) from the execute stage and drives the controller's address, write-data and write-enable lines. Loads are sign- or zero-extended. Because the memory interface has no byte enables, sub-word stores run as read-modify-write. Sits between the core pipeline and `memory_controller`, one outstanding request at a time.

---
 rtl/load_store_unit.sv | 94 +++++++++
 tb/tb_load_store_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: RISC-V load/store initiator with sign/zero-extended loads, RMW sub-word stores, optional LSU_MISALIGN_TRAP_EN misalignment trap
module load_store_unit #(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        clk_in,
  input  logic        rst_low_in,
  input  logic        req_valid_in,
  output logic        req_ready_out,
  input  logic        req_we_in,
  input  logic [2:0]  req_funct3_in,
  input  logic [31:0] req_addr_in,
  input  logic [31:0] req_wr_data_in,
  output logic        resp_valid_out,
  output logic [31:0] resp_rd_data_out,
  output logic        resp_err_out,
  output logic [31:0] mem_addr_out,
  output logic [31:0] mem_wr_data_out,
  input  logic [31:0] mem_rd_data_in,
  output logic        mem_we_out,
  output logic        busy_out
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  state_t state, state_nx;
  logic [31:0] addr_q, wdata_q, rd_word_q, rd_data_q;
  logic [2:0] f3_q;
  logic we_q, err_q;
  logic [1:0] cnt;
  logic accept, req_w, mis_req, last_rd, is_b, is_h, uns;
  logic [7:0] byte_v;
  logic [15:0] half_v;
  logic [31:0] ld_val, wide, mask, merged;
  assign accept = state == IDLE && req_valid_in;
  assign req_w = req_funct3_in[1];
`ifdef LSU_MISALIGN_TRAP_EN
  assign mis_req = (req_funct3_in[1:0] == 2'b01 && req_addr_in[0]) || (req_w && req_addr_in[1:0] != 2'b00);
`else
  assign mis_req = 1'b0;
`endif
  assign last_rd = cnt == 2'(RD_LATENCY);
  assign is_b = f3_q[1:0] == 2'b00;
  assign is_h = f3_q[1:0] == 2'b01;
  assign uns = f3_q[2];
  assign byte_v = 8'(mem_rd_data_in >> {addr_q[1:0], 3'b000});
  assign half_v = addr_q[1] ? mem_rd_data_in[31:16] : mem_rd_data_in[15:0];
  assign ld_val = is_b ? {{24{~uns & byte_v[7]}}, byte_v} : is_h ? {{16{~uns & half_v[15]}}, half_v} : mem_rd_data_in;
  assign wide = is_b ? {4{wdata_q[7:0]}} : is_h ? {2{wdata_q[15:0]}} : wdata_q;
  assign mask = is_b ? 32'hFF << {addr_q[1:0], 3'b000} : is_h ? (addr_q[1] ? 32'hFFFF_0000 : 32'h0000_FFFF) : '1;
  assign merged = (rd_word_q & ~mask) | (wide & mask);
  always_ff @(posedge clk_in or negedge rst_low_in)
    if (!rst_low_in) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (req_valid_in ? (mis_req ? RESP : (req_we_in && req_w) ? WRITE : READ) : IDLE) :
               state == READ ? (last_rd ? (we_q ? WRITE : RESP) : READ) :
               state == WRITE ? RESP : IDLE;
  always_ff @(posedge clk_in or negedge rst_low_in) begin
    if (!rst_low_in) begin
      addr_q <= '0;
      wdata_q <= '0;
      rd_word_q <= '0;
      rd_data_q <= '0;
      f3_q <= '0;
      we_q <= 1'b0;
      err_q <= 1'b0;
      cnt <= '0;
    end else begin
      if (accept) begin
        addr_q <= req_addr_in;
        wdata_q <= req_wr_data_in;
        f3_q <= req_funct3_in;
        we_q <= req_we_in;
        err_q <= mis_req;
        cnt <= '0;
        if (mis_req) rd_data_q <= '0;
      end
      if (state == READ) begin
        cnt <= cnt + 2'd1;
        if (last_rd) begin
          rd_word_q <= mem_rd_data_in;
          if (!we_q) rd_data_q <= ld_val;
        end
      end
      if (state == WRITE) rd_data_q <= '0;
    end
  end
  assign req_ready_out = state == IDLE;
  assign busy_out = state != IDLE;
  assign resp_valid_out = state == RESP;
  assign resp_err_out = resp_valid_out & err_q;
  assign resp_rd_data_out = rd_data_q;
  assign mem_we_out = state == WRITE;
  assign mem_addr_out = (state == READ || state == WRITE) ? {addr_q[31:2], 2'b00} : '0;
  assign mem_wr_data_out = mem_we_out ? merged : '0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven check of load_store_unit at RD_LATENCY 1 and 3 against a latency-modelled word memory
module tb_load_store_unit;
  typedef struct {
    int i;
    logic pl;
    logic [31:0] pre;
    logic we;
    logic [2:0] f3;
    logic [31:0] a, wd, rd;
    int lat, nrd, nwe;
    logic [31:0] wdo, word;
    logic err;
  } vec_t;
  logic clk = 1'b0;
  logic rst_low;
  logic req_valid [2], req_we [2], ready [2], resp_valid [2], resp_err [2], mem_we [2], busy [2];
  logic [2:0] f3 [2];
  logic [31:0] req_addr [2], req_wd [2], resp_rd [2], mem_addr [2], mem_wd [2], mem_rd [2];
  logic [31:0] mem [2][256];
  logic pv [2][3];
  logic [31:0] pa [2][3];
  logic pl_en [2];
  logic [31:0] pl_a, pl_d;
  vec_t vq [$];
  int total = 0, passed = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : gi
    load_store_unit #(.RD_LATENCY(g == 0 ? 1 : 3)) dut (
      .clk_in(clk), .rst_low_in(rst_low),
      .req_valid_in(req_valid[g]), .req_ready_out(ready[g]), .req_we_in(req_we[g]),
      .req_funct3_in(f3[g]), .req_addr_in(req_addr[g]), .req_wr_data_in(req_wd[g]),
      .resp_valid_out(resp_valid[g]), .resp_rd_data_out(resp_rd[g]), .resp_err_out(resp_err[g]),
      .mem_addr_out(mem_addr[g]), .mem_wr_data_out(mem_wd[g]), .mem_rd_data_in(mem_rd[g]),
      .mem_we_out(mem_we[g]), .busy_out(busy[g])
    );
  end
  always @(posedge clk)
    for (int g = 0; g < 2; g++) begin
      if (pl_en[g]) mem[g][pl_a[9:2]] <= pl_d;
      else if (mem_we[g]) mem[g][mem_addr[g][9:2]] <= mem_wd[g];
      pv[g][0] <= busy[g] & ~mem_we[g] & ~resp_valid[g];
      pa[g][0] <= mem_addr[g];
      for (int k = 1; k < 3; k++) begin
        pv[g][k] <= pv[g][k-1];
        pa[g][k] <= pa[g][k-1];
      end
    end
  always_comb
    for (int g = 0; g < 2; g++)
      mem_rd[g] = pv[g][g == 0 ? 0 : 2] ? mem[g][pa[g][g == 0 ? 0 : 2][9:2]] : 32'hBAD0_BAD0;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  task automatic add(int i, logic pl, logic [31:0] pre, logic we, logic [2:0] f3v, logic [31:0] a, wd, rd,
                     int lat, nrd, nwe, logic [31:0] wdo, word, logic err);
    vq.push_back('{i, pl, pre, we, f3v, a, wd, rd, lat, nrd, nwe, wdo, word, err});
  endtask
  task automatic run_vec(int k, vec_t v);
    int i, lat, nrd, nwe, bad;
    logic [31:0] wdc, rd, wa;
    logic err, rdy;
    i = v.i;
    wa = {v.a[31:2], 2'b00};
    @(negedge clk);
    if (v.pl) begin
      pl_en[i] = 1'b1; pl_a = v.a; pl_d = v.pre;
      @(negedge clk);
      pl_en[i] = 1'b0;
    end
    req_valid[i] = 1'b1; req_we[i] = v.we; f3[i] = v.f3; req_addr[i] = v.a; req_wd[i] = v.wd;
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0; req_we[i] = ~v.we; f3[i] = 3'b011; req_addr[i] = '1; req_wd[i] = '1;
    lat = -1; nrd = 0; nwe = 0; bad = 0; wdc = '0; rd = '0; err = 1'b0; rdy = 1'b1;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(negedge clk);
      if (mem_we[i]) begin
        nwe++;
        wdc = mem_wd[i];
        if (mem_addr[i] !== wa) bad++;
      end else if (busy[i] && !resp_valid[i]) begin
        nrd++;
        if (mem_addr[i] !== wa) bad++;
      end
      if (resp_valid[i]) begin
        lat = c; rd = resp_rd[i]; err = resp_err[i]; rdy = ready[i];
      end
    end
    chk($sformatf("v%0d_rdata", k), rd, v.rd);
    chk($sformatf("v%0d_err", k), 32'(err), 32'(v.err));
    chk($sformatf("v%0d_latency", k), 32'(lat), 32'(v.lat));
    chk($sformatf("v%0d_read_cycles", k), 32'(nrd), 32'(v.nrd));
    chk($sformatf("v%0d_we_pulses", k), 32'(nwe), 32'(v.nwe));
    chk($sformatf("v%0d_we_data", k), wdc, v.wdo);
    chk($sformatf("v%0d_mem_word", k), mem[i][v.a[9:2]], v.word);
    chk($sformatf("v%0d_addr_bad", k), 32'(bad), 32'd0);
    chk($sformatf("v%0d_ready_in_resp", k), 32'(rdy), 32'd0);
    @(negedge clk);
    chk($sformatf("v%0d_pulse_end", k), 32'(resp_valid[i]), 32'd0);
    chk($sformatf("v%0d_rdata_hold", k), resp_rd[i], v.rd);
    chk($sformatf("v%0d_ready_after", k), 32'(ready[i]), 32'd1);
  endtask
  initial begin
    int seen, extra;
    for (int g = 0; g < 2; g++) begin
      req_valid[g] = 1'b0; req_we[g] = 1'b0; f3[g] = '0; req_addr[g] = '0; req_wd[g] = '0; pl_en[g] = 1'b0;
    end
    pl_a = '0; pl_d = '0;
    rst_low = 1'b0;
    add(0, 1, 32'h8899AABB, 0, 3'b000, 32'h103, 0, 32'hFFFFFF88, 3, 2, 0, 0, 32'h8899AABB, 0);
    add(0, 1, 32'h8899AABB, 0, 3'b100, 32'h103, 0, 32'h00000088, 3, 2, 0, 0, 32'h8899AABB, 0);
    add(0, 1, 32'h8899AABB, 0, 3'b001, 32'h102, 0, 32'hFFFF8899, 3, 2, 0, 0, 32'h8899AABB, 0);
    add(0, 1, 32'h8899AABB, 0, 3'b101, 32'h100, 0, 32'h0000AABB, 3, 2, 0, 0, 32'h8899AABB, 0);
    add(0, 1, 32'h12347F56, 0, 3'b000, 32'h101, 0, 32'h0000007F, 3, 2, 0, 0, 32'h12347F56, 0);
    add(0, 1, 32'h11223344, 1, 3'b000, 32'h101, 32'hA5, 0, 4, 2, 1, 32'h1122A544, 32'h1122A544, 0);
    add(0, 0, 0, 0, 3'b010, 32'h100, 0, 32'h1122A544, 3, 2, 0, 0, 32'h1122A544, 0);
    add(0, 1, 0, 1, 3'b010, 32'h200, 32'hDEADBEEF, 0, 2, 0, 1, 32'hDEADBEEF, 32'hDEADBEEF, 0);
    add(0, 1, 32'hDEADBEEF, 1, 3'b001, 32'h206, 32'h1234ABCD, 0, 4, 2, 1, 32'hABCDBEEF, 32'hABCDBEEF, 0);
    add(0, 1, 0, 1, 3'b100, 32'h203, 32'hFFFFFF77, 0, 4, 2, 1, 32'h77000000, 32'h77000000, 0);
    add(0, 1, 32'hCAFEF00D, 0, 3'b111, 32'h208, 0, 32'hCAFEF00D, 3, 2, 0, 0, 32'hCAFEF00D, 0);
    add(1, 1, 32'h80017FFF, 0, 3'b001, 32'h102, 0, 32'hFFFF8001, 5, 4, 0, 0, 32'h80017FFF, 0);
    add(1, 1, 32'hFFFFFFFF, 1, 3'b000, 32'h010, 32'h5A, 0, 6, 4, 1, 32'hFFFFFF5A, 32'hFFFFFF5A, 0);
    add(1, 1, 32'h80017FFF, 0, 3'b101, 32'h100, 0, 32'h00007FFF, 5, 4, 0, 0, 32'h80017FFF, 0);
    add(1, 1, 0, 1, 3'b010, 32'h20C, 32'h01234567, 0, 2, 0, 1, 32'h01234567, 32'h01234567, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    add(0, 1, 32'h01020304, 0, 3'b010, 32'h101, 0, 0, 1, 0, 0, 0, 32'h01020304, 1);
    add(0, 1, 32'h80001234, 0, 3'b001, 32'h103, 0, 0, 1, 0, 0, 0, 32'h80001234, 1);
    add(0, 1, 32'hAAAAAAAA, 1, 3'b010, 32'h302, 32'h55555555, 0, 1, 0, 0, 0, 32'hAAAAAAAA, 1);
    add(0, 1, 32'hAAAAAAAA, 1, 3'b001, 32'h301, 32'h0000BEEF, 0, 1, 0, 0, 0, 32'hAAAAAAAA, 1);
`else
    add(0, 1, 32'h01020304, 0, 3'b010, 32'h101, 0, 32'h01020304, 3, 2, 0, 0, 32'h01020304, 0);
    add(0, 1, 32'h80001234, 0, 3'b001, 32'h103, 0, 32'hFFFF8000, 3, 2, 0, 0, 32'h80001234, 0);
    add(0, 1, 32'hAAAAAAAA, 1, 3'b010, 32'h302, 32'h55555555, 0, 2, 0, 1, 32'h55555555, 32'h55555555, 0);
    add(0, 1, 32'hAAAAAAAA, 1, 3'b001, 32'h301, 32'h0000BEEF, 0, 4, 2, 1, 32'hAAAABEEF, 32'hAAAABEEF, 0);
`endif
    repeat (2) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("rst%0d_ready", g), 32'(ready[g]), 32'd1);
      chk($sformatf("rst%0d_busy", g), 32'(busy[g]), 32'd0);
      chk($sformatf("rst%0d_resp_valid", g), 32'(resp_valid[g]), 32'd0);
      chk($sformatf("rst%0d_err", g), 32'(resp_err[g]), 32'd0);
      chk($sformatf("rst%0d_we", g), 32'(mem_we[g]), 32'd0);
      chk($sformatf("rst%0d_rdata", g), resp_rd[g], 32'd0);
      chk($sformatf("rst%0d_mem_addr", g), mem_addr[g], 32'd0);
      chk($sformatf("rst%0d_mem_wdata", g), mem_wd[g], 32'd0);
    end
    rst_low = 1'b1;
    foreach (vq[k]) run_vec(k, vq[k]);
    @(negedge clk);
    pl_en[0] = 1'b1; pl_a = 32'h140; pl_d = 32'h11112222;
    @(negedge clk);
    pl_en[0] = 1'b0;
    req_valid[0] = 1'b1; req_we[0] = 1'b1; f3[0] = 3'b001; req_addr[0] = 32'h142; req_wd[0] = 32'h9999;
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      @(negedge clk);
      if (mem_we[0]) seen = 1;
    end
    chk("rstmid_write_seen", 32'(seen), 32'd1);
    rst_low = 1'b0;
    #1;
    chk("rstmid_we_drop", 32'(mem_we[0]), 32'd0);
    chk("rstmid_busy_drop", 32'(busy[0]), 32'd0);
    @(negedge clk);
    extra = resp_valid[0] ? 1 : 0;
    rst_low = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (resp_valid[0] || mem_we[0]) extra++;
    end
    chk("rstmid_no_resp", 32'(extra), 32'd0);
    chk("rstmid_ready", 32'(ready[0]), 32'd1);
    chk("rstmid_mem_word", mem[0][8'h50], 32'h11112222);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
